// File: rtl/spart_pkg.sv
// spart_pkg: shared definitions for the SPART echo node.
//   - bus register addresses seen on ioaddr
//   - baud divisor lookup indexed by the br_cfg switches
//   - driver FSM and SPART TX/RX state encodings
package spart_pkg;

  // Register map on the internal processor-style bus.
  localparam logic [1:0] ADDR_RXTX   = 2'b00;  // rd: receive buffer, wr: TX buffer
  localparam logic [1:0] ADDR_STATUS = 2'b01;  // rd: {6'b0, tbr, rda}
  localparam logic [1:0] ADDR_DBL    = 2'b10;  // wr: divisor low byte
  localparam logic [1:0] ADDR_DBH    = 2'b11;  // wr: divisor high byte

  // Slowest selectable baud; each br_cfg step doubles it.
  localparam int unsigned BAUD_BASE = 4800;

  // Driver FSM encoding is visible to debug, so values are pinned.
  typedef enum logic [2:0] {
    DRV_CFG_LO  = 3'd0,
    DRV_CFG_HI  = 3'd1,
    DRV_READ    = 3'd2,
    DRV_WAIT_RX = 3'd3,
    DRV_WRITE   = 3'd4,
    DRV_WAIT_TX = 3'd5
  } drv_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Divisor table: a bit lasts divisor+1 clocks, so divisor = clk/baud - 1
  // (truncating). At 50 MHz this gives 10415, 5207, 2603, 1301.
  function automatic logic [15:0] baud_divisor(input int unsigned clk_hz,
                                               input logic [1:0]  sel);
    int unsigned baud;
    baud = BAUD_BASE << sel;
    return 16'(clk_hz / baud - 1);
  endfunction

endpackage

// File: rtl/spart_core.sv
// spart_core: 8N1 SPART with programmable baud divisor.
//
// Bus: iocs_i qualifies a single-cycle access with no wait states.
//   iorw_i=1 is a read: the core drives databus_io combinationally in that
//   same cycle, and releases it (Z) at all other times. iorw_i=0 is a
//   write: databus_io is sampled on the clock edge ending the cycle.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   iocs_i         chip select
//   iorw_i         1 = read, 0 = write
//   ioaddr_i[1:0]  register address (see spart_pkg)
//   databus_io[7:0] bidirectional data bus
//   rxd_i          serial in (idles high, asynchronous)
//   txd_o          serial out (idles high)
//   rda_o          receive data available
//   tbr_o          transmit buffer ready
module spart_core
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd10415
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       iocs_i,
  input  logic       iorw_i,
  input  logic [1:0] ioaddr_i,
  inout  wire  [7:0] databus_io,
  input  logic       rxd_i,
  output logic       txd_o,
  output logic       rda_o,
  output logic       tbr_o
);

  logic rd_sel, wr_sel;
  assign rd_sel = iocs_i & iorw_i;
  assign wr_sel = iocs_i & ~iorw_i;

  // ---------------------------------------------------------------- regs
  logic [15:0] divisor_q, divisor_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        rda_q, rda_d;

  // RX
  logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;

  // TX
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;

  logic tbr;
  assign tbr   = (tx_state_q == TX_IDLE);
  assign tbr_o = tbr;
  assign rda_o = rda_q;

  // ------------------------------------------------------------ bus read
  logic [7:0] rdata;
  always_comb begin
    rdata = 8'h00;
    case (ioaddr_i)
      ADDR_RXTX:   rdata = rx_buf_q;
      ADDR_STATUS: rdata = {6'b0, tbr, rda_q};
      default:     rdata = 8'h00;
    endcase
  end

  assign databus_io = rd_sel ? rdata : 8'hzz;

  // ------------------------------------------------------------- divisor
  always_comb begin
    divisor_d = divisor_q;
    if (wr_sel && ioaddr_i == ADDR_DBL) divisor_d[7:0]  = databus_io;
    if (wr_sel && ioaddr_i == ADDR_DBH) divisor_d[15:8] = databus_io;
  end

  // ------------------------------------------------------------------ RX
  // rxd is asynchronous: two flops to synchronise, a third for the edge.
  logic rx_fall, rx_tick, rx_mid;
  assign rx_fall = rxd_prev_q & ~rxd_sync_q;
  // >= keeps the counter bounded if the divisor shrinks mid-frame.
  assign rx_tick = (rx_state_q != RX_IDLE) && (rx_cnt_q >= divisor_q);
  assign rx_mid  = (rx_state_q != RX_IDLE) &&
                   (rx_cnt_q == {1'b0, divisor_q[15:1]});

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    rda_d      = rda_q;

    if (rd_sel && ioaddr_i == ADDR_RXTX) rda_d = 1'b0;

    if (rx_state_q == RX_IDLE || rx_tick) rx_cnt_d = '0;
    else                                  rx_cnt_d = rx_cnt_q + 16'd1;

    case (rx_state_q)
      RX_IDLE: if (rx_fall) rx_state_d = RX_START;
      RX_START: begin
        // High at mid-bit means the falling edge was a glitch.
        if (rx_mid && rxd_sync_q) rx_state_d = RX_IDLE;
        else if (rx_tick) begin
          rx_state_d = RX_DATA;
          rx_bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (rx_mid) rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
        if (rx_tick) begin
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // The stop level is not checked; a framing error still delivers.
        // A new byte wins over a same-cycle read clearing rda.
        if (rx_mid) begin
          rx_buf_d   = rx_shift_q;
          rda_d      = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ TX
  logic tx_tick, tx_load;
  assign tx_tick = (tx_state_q != TX_IDLE) && (tx_cnt_q >= divisor_q);
  assign tx_load = wr_sel && (ioaddr_i == ADDR_RXTX) && tbr;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;

    if (tx_state_q == TX_IDLE || tx_tick) tx_cnt_d = '0;
    else                                  tx_cnt_d = tx_cnt_q + 16'd1;

    case (tx_state_q)
      TX_IDLE: begin
        if (tx_load) begin
          tx_shift_d = databus_io;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: if (tx_tick) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    txd_o = 1'b1;
    case (tx_state_q)
      TX_START: txd_o = 1'b0;
      TX_DATA:  txd_o = tx_shift_q[0];
      default:  txd_o = 1'b1;
    endcase
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      divisor_q  <= DIV_RESET;
      rx_buf_q   <= 8'h00;
      rda_q      <= 1'b0;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      divisor_q  <= divisor_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

endmodule

// File: rtl/spart_echo.sv
// spart_echo: serial echo node. A driver FSM programs the SPART divisor
// from br_cfg once after reset, then loops: wait for a byte, read it,
// wait for the transmitter, write it back out.
//
// Ports:
//   clk     system clock (CLK_HZ)
//   rst     synchronous active-high reset
//   br_cfg  baud select 00=4800 01=9600 10=19200 11=38400
//   rxd     serial in, idles high
//   txd     serial out, idles high
//   rda     SPART receive data available
//   tbr     SPART transmit buffer ready
module spart_echo
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rxd,
  output logic       txd,
  output logic       rda,
  output logic       tbr
);

  wire  [7:0] databus;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  logic [7:0] wdata;

  drv_state_e state_q, state_d;
  logic [7:0] byte_q, byte_d;

  // br_cfg only matters while a CFG state is driving the bus.
  logic [15:0] cfg_div;
  assign cfg_div = baud_divisor(CLK_HZ, br_cfg);

  // The driver owns the bus only on writes; reads are driven by the core.
  assign databus = (iocs & ~iorw) ? wdata : 8'hzz;

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    iocs    = 1'b0;
    iorw    = 1'b1;
    ioaddr  = ADDR_RXTX;
    wdata   = 8'h00;
    case (state_q)
      DRV_CFG_LO: begin
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = ADDR_DBL;
        wdata   = cfg_div[7:0];
        state_d = DRV_CFG_HI;
      end
      DRV_CFG_HI: begin
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = ADDR_DBH;
        wdata   = cfg_div[15:8];
        state_d = DRV_WAIT_RX;
      end
      DRV_WAIT_RX: if (rda) state_d = DRV_READ;
      DRV_READ: begin
        // Read data is valid on the bus within this same cycle.
        iocs    = 1'b1;
        iorw    = 1'b1;
        ioaddr  = ADDR_RXTX;
        byte_d  = databus;
        state_d = DRV_WAIT_TX;
      end
      DRV_WAIT_TX: if (tbr) state_d = DRV_WRITE;
      DRV_WRITE: begin
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = ADDR_RXTX;
        wdata   = byte_q;
        state_d = DRV_WAIT_RX;
      end
      default: state_d = DRV_CFG_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DRV_CFG_LO;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
    end
  end

  spart_core #(
    .DIV_RESET (baud_divisor(CLK_HZ, 2'b00))
  ) u_core (
    .clk_i      (clk),
    .rst_i      (rst),
    .iocs_i     (iocs),
    .iorw_i     (iorw),
    .ioaddr_i   (ioaddr),
    .databus_io (databus),
    .rxd_i      (rxd),
    .txd_o      (txd),
    .rda_o      (rda),
    .tbr_o      (tbr)
  );

endmodule

// File: tb/tb_spart_echo.sv
// tb_spart_echo: directed bench for spart_echo. A second spart_core (u_c2)
// listens on the echo node's txd and is driven directly through its bus.
module tb_spart_echo;

  localparam int BIT  = 1302;   // 38400 baud at 50 MHz
  localparam int HALF = 651;
  localparam logic [1:0] A_RXTX = 2'b00, A_STATUS = 2'b01;
  localparam logic [1:0] A_DBL  = 2'b10, A_DBH    = 2'b11;

  // ------------------------------------------------------ clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b00;
  logic       rxd = 1'b1;
  wire        txd, rda, tbr;

  always #10 clk = ~clk;

  logic       c2_iocs = 1'b0, c2_iorw = 1'b0, c2_oe = 1'b0;
  logic [1:0] c2_addr = 2'b00;
  logic [7:0] c2_drv = 8'h00;
  wire  [7:0] c2_db;
  wire        c2_txd, c2_rda, c2_tbr;
  assign c2_db = c2_oe ? c2_drv : 8'hzz;

  spart_echo dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rxd(rxd),
    .txd(txd), .rda(rda), .tbr(tbr)
  );

  spart_core u_c2 (
    .clk_i(clk), .rst_i(rst), .iocs_i(c2_iocs), .iorw_i(c2_iorw),
    .ioaddr_i(c2_addr), .databus_io(c2_db), .rxd_i(txd),
    .txd_o(c2_txd), .rda_o(c2_rda), .tbr_o(c2_tbr)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Scoreboard of expected serial bits (start, data LSB first, stop).
  logic [0:0] exp_q[$];

  // ------------------------------------------------------ driver tasks
  // Bus tasks are entered on a negedge and return on the next negedge.
  task automatic c2_write(input logic [1:0] a, input logic [7:0] d);
    c2_iocs = 1'b1; c2_iorw = 1'b0; c2_addr = a; c2_drv = d; c2_oe = 1'b1;
    @(negedge clk);
    c2_iocs = 1'b0; c2_oe = 1'b0;
  endtask

  task automatic c2_read(input logic [1:0] a, output logic [7:0] d);
    c2_iocs = 1'b1; c2_iorw = 1'b1; c2_addr = a; c2_oe = 1'b0;
    #1 d = c2_db;
    @(negedge clk);
    c2_iocs = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
  endtask

  // Drives a frame on rxd, changing each bit on the receiver's shift pulse.
  task automatic send_rx_byte(input logic [7:0] b, output bit ok);
    int n;
    ok = 1'b1;
    rxd = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n = 0;
      while (dut.u_core.rx_tick !== 1'b1 && n < 3 * BIT) begin
        @(negedge clk); n++;
      end
      if (n >= 3 * BIT) ok = 1'b0;
      rxd = (i < 8) ? b[i] : 1'b1;
      @(negedge clk);
    end
  endtask

  // ------------------------------------------------------ tests
  task automatic test_reset_4800();
    br_cfg = 2'b00; rxd = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b want 1", txd); end
    tests_run++; if (tbr !== 1'b1) begin tests_failed++; $display("FAIL reset_tbr: got %b want 1", tbr); end
    tests_run++; if (rda !== 1'b0) begin tests_failed++; $display("FAIL reset_rda: got %b want 0", rda); end
    tests_run++; if (dut.state_q !== 3'd0) begin tests_failed++; $display("FAIL reset_drv_state: got %0d want 0", dut.state_q); end
    tests_run++; if (dut.u_core.divisor_q !== 16'd10415) begin tests_failed++; $display("FAIL reset_divisor: got %0d want 10415", dut.u_core.divisor_q); end
    tests_run++; if (dut.u_core.rx_buf_q !== 8'h00) begin tests_failed++; $display("FAIL reset_rxbuf: got %h want 00", dut.u_core.rx_buf_q); end
    tests_run++; if (dut.u_core.tx_state_q !== 2'd0) begin tests_failed++; $display("FAIL reset_tx_state: got %0d want 0", dut.u_core.tx_state_q); end
    rst = 1'b0;
    #1;
    tests_run++; if ({dut.iocs, dut.iorw, dut.ioaddr, dut.databus} !== {1'b1, 1'b0, 2'b10, 8'hAF})
      begin tests_failed++; $display("FAIL cfg_lo_write: got cs=%b rw=%b a=%b d=%h want 1 0 10 af", dut.iocs, dut.iorw, dut.ioaddr, dut.databus); end
    @(negedge clk);
    tests_run++; if ({dut.state_q, dut.ioaddr, dut.databus} !== {3'd1, 2'b11, 8'h28})
      begin tests_failed++; $display("FAIL cfg_hi_write: got st=%0d a=%b d=%h want 1 11 28", dut.state_q, dut.ioaddr, dut.databus); end
    @(negedge clk);
    tests_run++; if (dut.state_q !== 3'd3 || dut.iocs !== 1'b0)
      begin tests_failed++; $display("FAIL cfg_done: got st=%0d cs=%b want 3 0", dut.state_q, dut.iocs); end
  endtask

  task automatic test_reset_38400();
    br_cfg = 2'b11; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (dut.databus !== 8'h15) begin tests_failed++; $display("FAIL cfg38k_lo: got %h want 15", dut.databus); end
    @(negedge clk);
    tests_run++; if (dut.databus !== 8'h05) begin tests_failed++; $display("FAIL cfg38k_hi: got %h want 05", dut.databus); end
    @(negedge clk);
    tests_run++; if (dut.u_core.divisor_q !== 16'd1301) begin tests_failed++; $display("FAIL cfg38k_div: got %0d want 1301", dut.u_core.divisor_q); end
    // br_cfg is ignored once configuration is done.
    br_cfg = 2'b00;
    repeat (5) @(negedge clk);
    tests_run++; if (dut.u_core.divisor_q !== 16'd1301 || dut.state_q !== 3'd3)
      begin tests_failed++; $display("FAIL brcfg_ignored: got div=%0d st=%0d want 1301 3", dut.u_core.divisor_q, dut.state_q); end
  endtask

  task automatic test_c2_config();
    logic [7:0] d;
    c2_write(A_DBL, 8'h15);
    c2_write(A_DBH, 8'h05);
    tests_run++; if (u_c2.divisor_q !== 16'd1301) begin tests_failed++; $display("FAIL c2_divisor: got %0d want 1301", u_c2.divisor_q); end
    c2_read(A_STATUS, d);
    tests_run++; if (d !== 8'h02) begin tests_failed++; $display("FAIL c2_status_idle: got %h want 02", d); end
  endtask

  task automatic test_rx_frame();
    bit ok;
    int n;
    send_rx_byte(8'h48, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rx_shift_timeout: got no shift pulse want pulse per bit"); end
    n = 0;
    while (rda !== 1'b1 && n < 2 * BIT) begin @(negedge clk); n++; end
    tests_run++; if (rda !== 1'b1) begin tests_failed++; $display("FAIL rx_rda: got %b want 1", rda); end
    tests_run++; if (dut.u_core.rx_buf_q !== 8'h48) begin tests_failed++; $display("FAIL rx_buffer: got %h want 48", dut.u_core.rx_buf_q); end
    tests_run++; if (dut.state_q !== 3'd3) begin tests_failed++; $display("FAIL rx_drv_wait: got %0d want 3", dut.state_q); end
  endtask

  task automatic test_echo();
    int first_rise, bit_idx, n;
    logic [0:0] e;
    logic [7:0] d;
    @(negedge clk);
    tests_run++; if ({dut.state_q, dut.databus, rda} !== {3'd2, 8'h48, 1'b1})
      begin tests_failed++; $display("FAIL drv_read: got st=%0d d=%h rda=%b want 2 48 1", dut.state_q, dut.databus, rda); end
    @(negedge clk);
    tests_run++; if (rda !== 1'b0 || dut.state_q !== 3'd5)
      begin tests_failed++; $display("FAIL rda_clear: got rda=%b st=%0d want 0 5", rda, dut.state_q); end
    @(negedge clk);
    tests_run++; if ({dut.state_q, dut.iorw, dut.databus} !== {3'd4, 1'b0, 8'h48})
      begin tests_failed++; $display("FAIL drv_write: got st=%0d rw=%b d=%h want 4 0 48", dut.state_q, dut.iorw, dut.databus); end
    @(negedge clk);
    tests_run++; if (txd !== 1'b0 || tbr !== 1'b0)
      begin tests_failed++; $display("FAIL tx_start: got txd=%b tbr=%b want 0 0", txd, tbr); end
    push_frame(8'h48);
    first_rise = -1; bit_idx = 0;
    for (int k = 1; k <= 9 * BIT + HALF; k++) begin
      @(negedge clk);
      if (txd === 1'b1 && first_rise < 0) first_rise = k;
      if (k == HALF + BIT * bit_idx) begin
        e = exp_q.pop_front();
        tests_run++; if (txd !== e[0]) begin tests_failed++; $display("FAIL echo_bit%0d: got %b want %b", bit_idx, txd, e[0]); end
        bit_idx++;
      end
    end
    // 0x48 frame stays low for start + bits 0..2: four bit periods.
    tests_run++; if (first_rise != 4 * BIT) begin tests_failed++; $display("FAIL bit_period: got %0d want %0d", first_rise, 4 * BIT); end
    n = 0;
    while (c2_rda !== 1'b1 && n < 3 * BIT) begin @(negedge clk); n++; end
    tests_run++; if (c2_rda !== 1'b1) begin tests_failed++; $display("FAIL c2_rda: got %b want 1", c2_rda); end
    tests_run++; if (u_c2.rx_buf_q !== 8'h48) begin tests_failed++; $display("FAIL c2_buffer: got %h want 48", u_c2.rx_buf_q); end
    c2_read(A_RXTX, d);
    tests_run++; if (d !== 8'h48) begin tests_failed++; $display("FAIL c2_read_data: got %h want 48", d); end
    tests_run++; if (c2_rda !== 1'b0) begin tests_failed++; $display("FAIL c2_rda_clear: got %b want 0", c2_rda); end
    n = 0;
    while (tbr !== 1'b1 && n < 2 * BIT) begin @(negedge clk); n++; end
    tests_run++; if ({tbr, txd, dut.u_core.tx_state_q, dut.state_q} !== {1'b1, 1'b1, 2'd0, 3'd3})
      begin tests_failed++; $display("FAIL echo_done: got tbr=%b txd=%b tx=%0d st=%0d want 1 1 0 3", tbr, txd, dut.u_core.tx_state_q, dut.state_q); end
  endtask

  task automatic test_tx_status();
    int bit_idx, n;
    logic [0:0] e;
    logic [7:0] d;
    c2_write(A_RXTX, 8'hA5);                  // k = 0
    tests_run++; if (c2_txd !== 1'b0 || c2_tbr !== 1'b0)
      begin tests_failed++; $display("FAIL c2_tx_start: got txd=%b tbr=%b want 0 0", c2_txd, c2_tbr); end
    c2_write(A_RXTX, 8'h3C);                  // k = 1, must be ignored
    c2_read(A_STATUS, d);                     // k = 2
    tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL status_mid_tx: got %h want 00", d); end
    push_frame(8'hA5);
    bit_idx = 0;
    for (int k = 3; k <= 9 * BIT + HALF; k++) begin
      @(negedge clk);
      if (k == HALF + BIT * bit_idx) begin
        e = exp_q.pop_front();
        tests_run++; if (c2_txd !== e[0]) begin tests_failed++; $display("FAIL c2_tx_bit%0d: got %b want %b", bit_idx, c2_txd, e[0]); end
        bit_idx++;
      end
    end
    n = 0;
    while (c2_tbr !== 1'b1 && n < 2 * BIT) begin @(negedge clk); n++; end
    tests_run++; if ({c2_tbr, c2_txd, u_c2.tx_state_q} !== {1'b1, 1'b1, 2'd0})
      begin tests_failed++; $display("FAIL c2_tx_done: got tbr=%b txd=%b tx=%0d want 1 1 0", c2_tbr, c2_txd, u_c2.tx_state_q); end
    c2_read(A_STATUS, d);
    tests_run++; if (d !== 8'h02) begin tests_failed++; $display("FAIL status_after_tx: got %h want 02", d); end
  endtask

  task automatic test_false_start();
    bit rose;
    rxd = 1'b0;
    repeat (300) @(negedge clk);
    tests_run++; if (dut.u_core.rx_state_q === 2'd0) begin tests_failed++; $display("FAIL glitch_seen: got rx=%0d want nonzero", dut.u_core.rx_state_q); end
    rxd = 1'b1;
    rose = 1'b0;
    for (int k = 0; k < 2 * BIT; k++) begin
      @(negedge clk);
      if (rda === 1'b1) rose = 1'b1;
      if (k == 700) begin
        tests_run++; if (dut.u_core.rx_state_q !== 2'd0) begin tests_failed++; $display("FAIL glitch_reject: got rx=%0d want 0", dut.u_core.rx_state_q); end
      end
    end
    tests_run++; if (rose !== 1'b0) begin tests_failed++; $display("FAIL glitch_rda: got 1 want 0"); end
    tests_run++; if (dut.state_q !== 3'd3) begin tests_failed++; $display("FAIL glitch_drv: got %0d want 3", dut.state_q); end
  endtask

  // ------------------------------------------------------ sequence / report
  initial begin
    test_reset_4800();
    test_reset_38400();
    test_c2_config();
    test_rx_frame();
    test_echo();
    test_tx_status();
    test_false_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog: got no end of test want finish before 150000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
